st_outstanding_ctrl: RTL and testbench
======================================

# st_outstanding_ctrl

Issue controller for stores bound for the write-through data cache. Tracks how many stores have been handed to the cache write buffer and not yet acknowledged, and throttles new issues at the configured outstanding-store limit. Sequences fence/drain requests from the controller: blocks new stores, waits until all outstanding stores have completed, then acknowledges. Sits between the store unit's commit path and the cache request port.

## Interface
- `MaxOutstanding`, default 7: maximum number of unacknowledged stores; legal range 1..255.
- `CntWidth`, default `$clog2(MaxOutstanding+1)`: width of the outstanding counter.
- `StallCntWidth`, default 32: width of the stall performance counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `st_req_i`  in  1  store unit requests to issue one store.
- `st_gnt_o`  out  1  issue granted; a store is issued in any cycle where `st_req_i & st_gnt_o`.
- `st_ack_i`  in  1  the cache reports completion of one outstanding store.
- `fence_req_i`  in  1  fence/drain request; a level held until `fence_ack_o` or `flush_i`.
- `flush_i`  in  1  aborts a pending fence, for example on an exception.
- `fence_ack_o`  out  1  one-cycle pulse; all stores issued before the fence have completed.
- `busy_o`  out  1  `outstanding_o != 0`.
- `outstanding_o`  out  CntWidth  current outstanding count (registered).
- `err_underflow_o`  out  1  sticky; an acknowledge arrived while the count was 0.
- `stall_cnt_o`  out  StallCntWidth  count of cycles in which a store request was refused.

## Operation
- **Counter update.** `cnt_next = cnt + issue - ack_valid`, where `ack_valid = st_ack_i & (cnt != 0)`.
  - Issue and valid ack in the same cycle leave the count unchanged.
  - The count never exceeds `MaxOutstanding` and never wraps.
- **Underflow.** `st_ack_i` while `cnt == 0`:
  - the ack is ignored;
  - `err_underflow_o` is set on the next cycle and holds until reset;
  - an issue in the same cycle still increments the count.
- **Grant rule.** `st_gnt_o = (state == IDLE) & ~fence_req_i & (cnt < MaxOutstanding)`.
  - The grant depends only on registered state and `fence_req_i`.
  - There is no combinational path from `st_ack_i` to `st_gnt_o`.
  - At full count with an ack in the same cycle, `st_gnt_o` stays 0 that cycle.
- **State machine.** States are IDLE, DRAIN and ACK.
  - IDLE: if `fence_req_i` and `cnt == 0`, go to ACK. If `fence_req_i` and `cnt != 0`, go to DRAIN.
  - DRAIN: no grants. If `flush_i`, go to IDLE with no ack. Otherwise, if `cnt == 0`, go to ACK.
  - ACK: `fence_ack_o = 1` for exactly one cycle, then go to IDLE. `flush_i` in ACK is ignored; the ack still fires.
  - `flush_i` in IDLE has no effect.
- **Fence protocol.** The requester must drop `fence_req_i` in the cycle after `fence_ack_o`. If it is still high in IDLE, a new fence starts.

## Timing
- Reset values: state IDLE, `outstanding_o = 0`, `busy_o = 0`, `fence_ack_o = 0`, `err_underflow_o = 0`, `stall_cnt_o = 0`.
  - `st_gnt_o` is 0 while `rst_i` is high.
  - Reset during DRAIN or ACK returns to IDLE with no ack.
- `outstanding_o` reflects an issue or ack one cycle after it occurs.
- Fence latency:
  - 1 cycle when nothing is outstanding: `fence_req_i` in cycle N gives `fence_ack_o` in cycle N+1.
  - Otherwise, `fence_ack_o` arrives 2 cycles after the cycle in which the last ack is presented: count reaches 0 one cycle after, ACK is entered the following cycle.

## Configuration
- Macro: `ST_OUTSTANDING_STALL_CNT_EN`.
- Defined: `stall_cnt_o` increments in every cycle with `st_req_i & ~st_gnt_o`, saturates at all-ones, and resets to 0.
- Undefined: the counter logic is not built and `stall_cnt_o` is tied to 0. The port is present in both builds.

## Test plan
- **Reset:** assert `rst_i` mid-DRAIN with `cnt = 3` → next cycle all outputs are 0, state is IDLE, and no `fence_ack_o` fires.
- **Throttle:** `MaxOutstanding = 7`, `st_req_i` held high with no acks → 7 grants in consecutive cycles, then `st_gnt_o = 0` and `outstanding_o = 7`. One ack → `st_gnt_o = 1` in the following cycle, not in the ack cycle.
- **Simultaneous events:** at `cnt = 3`, issue and ack in the same cycle → `outstanding_o` stays 3.
- **Drain:** `cnt = 2`, `fence_req_i` from cycle 0, acks in cycles 2 and 4 → no grants during the fence and `fence_ack_o` high only in cycle 6. Empty fence: `fence_req_i` in cycle 0 → ack in cycle 1. `flush_i` in DRAIN → return to IDLE with no ack.
- **Underflow:** `st_ack_i` at `cnt = 0` → `err_underflow_o = 1` from the next cycle and stays high, with the count at 0. The same stimulus with a concurrent issue → count becomes 1.
- **Stall counter:** with the macro defined, a request refused for 5 cycles at full count → `stall_cnt_o = 5`. With the macro undefined → `stall_cnt_o = 0`.

Source files
------------

// File: rtl/st_outstanding_ctrl.sv
// st_outstanding_ctrl
//
// Issue controller for stores headed to the write-through data cache.
// It counts stores that have been handed to the cache write buffer and not
// yet acknowledged, and stops granting new stores once the configured limit
// is reached. It also sequences fence/drain requests: new stores are
// blocked, the controller waits for every outstanding store to complete,
// and then it acknowledges the fence with a single-cycle pulse.
//
// Optional feature macro: ST_OUTSTANDING_STALL_CNT_EN
//   defined   - stall_cnt_o counts cycles in which a store request was
//               refused. The counter saturates at all-ones.
//   undefined - no counter logic is built and stall_cnt_o is tied to 0.
//
// Parameters:
//   MaxOutstanding  maximum number of unacknowledged stores (1..255)
//   CntWidth        width of the outstanding counter
//   StallCntWidth   width of the stall performance counter
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous, active-high reset
//   st_req_i         store unit requests to issue one store
//   st_gnt_o         issue granted; a store issues when st_req_i & st_gnt_o
//   st_ack_i         cache reports completion of one outstanding store
//   fence_req_i      fence/drain request level
//   flush_i          aborts a pending fence
//   fence_ack_o      one-cycle pulse: all stores before the fence completed
//   busy_o           outstanding count is non-zero
//   outstanding_o    registered outstanding count
//   err_underflow_o  sticky: an ack arrived while the count was zero
//   stall_cnt_o      cycles in which a store request was refused
module st_outstanding_ctrl #(
  parameter int unsigned MaxOutstanding = 7,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1),
  parameter int unsigned StallCntWidth  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     st_req_i,
  output logic                     st_gnt_o,
  input  logic                     st_ack_i,
  input  logic                     fence_req_i,
  input  logic                     flush_i,
  output logic                     fence_ack_o,
  output logic                     busy_o,
  output logic [CntWidth-1:0]      outstanding_o,
  output logic                     err_underflow_o,
  output logic [StallCntWidth-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } state_e;

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  state_e              state;
  state_e              state_next;
  logic [CntWidth-1:0] cnt;
  logic [CntWidth-1:0] cnt_next;
  logic                cnt_zero;
  logic                issue;
  logic                ack_valid;
  logic                err_q;

  assign cnt_zero = (cnt == '0);

  // The grant is built only from registered state and fence_req_i, so an
  // ack arriving at full count cannot reopen the grant in that same cycle.
  assign st_gnt_o  = ~rst_i & (state == IDLE) & ~fence_req_i & (cnt < MaxCnt);
  assign issue     = st_req_i & st_gnt_o;
  // An ack at zero count is dropped and only flags the underflow error.
  assign ack_valid = st_ack_i & ~cnt_zero;

  always_comb begin
    cnt_next = cnt;
    if (issue && !ack_valid) begin
      cnt_next = cnt + CntWidth'(1);
    end else if (!issue && ack_valid) begin
      cnt_next = cnt - CntWidth'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fence_req_i) begin
          state_next = cnt_zero ? ACK : DRAIN;
        end
      end
      DRAIN: begin
        // A flush takes priority over a drain that completes in the same cycle.
        if (flush_i) begin
          state_next = IDLE;
        end else if (cnt_zero) begin
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (st_ack_i && cnt_zero) begin
        err_q <= 1'b1;
      end
    end
  end

  // Masking with reset ensures a reset asserted while in ACK does not
  // produce a fence acknowledge.
  assign fence_ack_o     = ~rst_i & (state == ACK);
  assign busy_o          = ~cnt_zero;
  assign outstanding_o   = cnt;
  assign err_underflow_o = err_q;

`ifdef ST_OUTSTANDING_STALL_CNT_EN
  logic [StallCntWidth-1:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (st_req_i && !st_gnt_o && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + StallCntWidth'(1);
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_st_outstanding_ctrl.sv
module tb_st_outstanding_ctrl;

  localparam int unsigned MaxOut = 7;
  localparam int unsigned CW     = $clog2(MaxOut + 1);
  localparam int unsigned SW     = 32;

`ifdef ST_OUTSTANDING_STALL_CNT_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          st_req_i = 1'b0;
  logic          st_ack_i = 1'b0;
  logic          fence_req_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          st_gnt_o;
  logic          fence_ack_o;
  logic          busy_o;
  logic [CW-1:0] outstanding_o;
  logic          err_underflow_o;
  logic [SW-1:0] stall_cnt_o;

  st_outstanding_ctrl #(
    .MaxOutstanding(MaxOut),
    .CntWidth      (CW),
    .StallCntWidth (SW)
  ) u_dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .st_req_i       (st_req_i),
    .st_gnt_o       (st_gnt_o),
    .st_ack_i       (st_ack_i),
    .fence_req_i    (fence_req_i),
    .flush_i        (flush_i),
    .fence_ack_o    (fence_ack_o),
    .busy_o         (busy_o),
    .outstanding_o  (outstanding_o),
    .err_underflow_o(err_underflow_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     cyc;
    logic   gnt;
    logic   ack;
    int     cnt;
    logic   busy;
    logic   err;
    longint stall;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: counts, a pending-fence flag, and the cycle at which
  // the fence acknowledge is due (-1 when not yet scheduled).
  int     m_cnt = 0;
  bit     m_err = 1'b0;
  longint m_stall = 0;
  bit     m_fence = 1'b0;
  int     m_ack_at = -1;
  int     t = 0;
  bit     last_ack = 1'b0;

  task automatic check(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit q, input bit a, input bit f, input bit fl);
    exp_t e;
    int   old;
    bit   issue;
    @(posedge clk);
    #1;
    rst_i       = r;
    st_req_i    = q;
    st_ack_i    = a;
    fence_req_i = f;
    flush_i     = fl;

    e.cyc   = t;
    e.gnt   = !r && !m_fence && !f && (m_cnt < int'(MaxOut));
    e.ack   = !r && (m_ack_at == t);
    e.cnt   = m_cnt;
    e.busy  = (m_cnt != 0);
    e.err   = m_err;
    e.stall = m_stall;
    exp_q.push_back(e);
    last_ack = e.ack;

    if (r) begin
      m_cnt    = 0;
      m_err    = 1'b0;
      m_stall  = 0;
      m_fence  = 1'b0;
      m_ack_at = -1;
    end else begin
      old   = m_cnt;
      issue = q && e.gnt;
      if (a && old == 0) m_err = 1'b1;
      m_cnt = old + (issue ? 1 : 0) - ((a && old > 0) ? 1 : 0);
      if (StallEn && q && !e.gnt && m_stall < 64'h0000_0000_FFFF_FFFF) m_stall++;
      if (m_ack_at == t) begin
        m_fence  = 1'b0;
        m_ack_at = -1;
      end else if (!m_fence) begin
        if (f) begin
          m_fence = 1'b1;
          if (old == 0) m_ack_at = t + 1;
        end
      end else if (m_ack_at < 0) begin
        if (fl) m_fence = 1'b0;
        else if (old == 0) m_ack_at = t + 1;
      end
    end
    t++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("st_gnt", mon_e.cyc, 64'(st_gnt_o), 64'(mon_e.gnt));
      check("fence_ack", mon_e.cyc, 64'(fence_ack_o), 64'(mon_e.ack));
      check("outstanding", mon_e.cyc, 64'(outstanding_o), 64'(mon_e.cnt));
      check("busy", mon_e.cyc, 64'(busy_o), 64'(mon_e.busy));
      check("err_underflow", mon_e.cyc, 64'(err_underflow_o), 64'(mon_e.err));
      check("stall_cnt", mon_e.cyc, 64'(stall_cnt_o), 64'(mon_e.stall));
    end
  end

  initial begin
    bit fence_lvl;
    bit drop_next;
    bit r, q, a, fl;

    repeat (3) cyc(1, 0, 0, 0, 0);

    // Throttle: 7 grants, refusals, ack at full count, regrant next cycle.
    repeat (9) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (5) cyc(0, 1, 0, 0, 0);

    // Down to 3, then simultaneous issue and ack, then down to 2.
    repeat (4) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Drain with count 2: acks in fence cycles 2 and 4, ack pulse in cycle 6.
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Empty fence.
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Flush during drain.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Reset in the middle of a drain with count 3.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Underflow alone, then underflow with a concurrent issue.
    cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // Randomized traffic with a requester that honours the fence protocol.
    fence_lvl = 1'b0;
    drop_next = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      q = ($urandom_range(0, 3) != 0);
      if (m_cnt > 0) a = ($urandom_range(0, 1) == 1);
      else           a = ($urandom_range(0, 99) == 0);
      if (drop_next) begin
        fence_lvl = 1'b0;
        drop_next = 1'b0;
      end else if (!fence_lvl && $urandom_range(0, 23) == 0) begin
        fence_lvl = 1'b1;
      end
      if (fence_lvl) fl = ($urandom_range(0, 19) == 0);
      else           fl = ($urandom_range(0, 49) == 0);
      cyc(r, q, a, fence_lvl, fl);
      if (fence_lvl && (last_ack || fl || r)) drop_next = 1'b1;
    end
    cyc(0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", t, 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
